// File: rtl/seq_pkg.sv
// Shared definitions for the pipeline session sequencer and its readback slot.
package seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      RD_REG,
      RD_MEM,
      DONE
   } state_t;

   localparam int NUM_REGS   = 32;
   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/readback_slot.sv
// One-deep readback stage: drives the core debug port, waits READ_LAT cycles,
// then holds the captured word on a valid/ready output.
module readback_slot #(
   parameter int READ_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   input  logic        req_is_mem,
   input  logic [4:0]  req_index,
   output logic        req_ready,
   output logic [31:0] check_address,
   output logic        data_or_reg,
   input  logic [31:0] core_value,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic        out_is_mem,
   output logic [4:0]  out_index,
   input  logic        out_ready,
   output logic        in_flight
);

   localparam int LAT_W = $clog2(READ_LAT + 1);

   logic             pending_q;
   logic [LAT_W-1:0] lat_q;
   logic             pend_mem_q;
   logic [4:0]       pend_idx_q;
   logic             capture;
   logic             take;
   logic             accept;

   // Valid/ready: a word moves when out_valid && out_ready at a rising edge;
   // out_data/out_is_mem/out_index never change while out_valid is high and
   // out_ready is low. The next read is issued on the capture edge so a
   // stream of reads overlaps the hold cycle of the previous word.
   assign capture   = pending_q && (lat_q == LAT_W'(READ_LAT)) && (!out_valid || out_ready);
   assign req_ready = !pending_q || capture;
   assign take      = req_valid && req_ready;
   assign accept    = out_valid && out_ready;
   assign in_flight = pending_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q     <= 1'b0;
         lat_q         <= '0;
         pend_mem_q    <= 1'b0;
         pend_idx_q    <= '0;
         check_address <= '0;
         data_or_reg   <= 1'b0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_is_mem    <= 1'b0;
         out_index     <= '0;
      end else if (clear) begin
         pending_q     <= 1'b0;
         lat_q         <= '0;
         pend_mem_q    <= 1'b0;
         pend_idx_q    <= '0;
         check_address <= '0;
         data_or_reg   <= 1'b0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_is_mem    <= 1'b0;
         out_index     <= '0;
      end else begin
         if (take) begin
            pending_q     <= 1'b1;
            lat_q         <= '0;
            pend_mem_q    <= req_is_mem;
            pend_idx_q    <= req_index;
            check_address <= req_addr;
            data_or_reg   <= req_is_mem;
         end else if (capture) begin
            pending_q     <= 1'b0;
            lat_q         <= '0;
            pend_mem_q    <= 1'b0;
            pend_idx_q    <= '0;
            check_address <= '0;
            data_or_reg   <= 1'b0;
         end else if (pending_q && (lat_q != LAT_W'(READ_LAT))) begin
            lat_q <= lat_q + LAT_W'(1);
         end

         if (capture) begin
            out_valid  <= 1'b1;
            out_data   <= core_value;
            out_is_mem <= pend_mem_q;
            out_index  <= pend_idx_q;
         end else if (accept) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_is_mem <= 1'b0;
            out_index  <= '0;
         end
      end
   end

endmodule

// File: rtl/pipeline_sequencer.sv
// Session controller for the RISC-V core: load program, run for a budget,
// dump registers and a data-memory window back to the host.
module pipeline_sequencer
   import seq_pkg::*;
#(
   parameter int IMEM_DEPTH = 256,
   parameter int RUN_W      = 16,
   parameter int MEM_WORDS  = 16,
   parameter int READ_LAT   = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_go,
   input  logic                          cmd_abort,
   input  logic [$clog2(IMEM_DEPTH):0]   prog_len,
   input  logic [RUN_W-1:0]              run_cycles,
   input  logic [31:0]                   mem_base,
   input  logic                          host_valid,
   input  logic [31:0]                   host_instr,
   output logic                          host_ready,
   output logic                          core_start,
   output logic                          core_data_or_reg,
   output logic [31:0]                   core_address,
   output logic [31:0]                   core_instruction,
   output logic [31:0]                   core_check_address,
   input  logic [31:0]                   core_value,
   output logic                          dump_valid,
   output logic [31:0]                   dump_data,
   output logic                          dump_is_mem,
   output logic [4:0]                    dump_index,
   input  logic                          dump_ready,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output state_t                        dbg_state
);

   localparam int PL_W  = $clog2(IMEM_DEPTH) + 1;
   localparam int IDX_W = 16;

   state_t            state_q, state_d;
   logic [PL_W-1:0]   prog_len_q;
   logic [RUN_W-1:0]  run_q;
   logic [31:0]       mem_base_q;
   logic [PL_W-1:0]   k_q;
   logic [RUN_W-1:0]  run_cnt_q;
   logic [IDX_W-1:0]  iss_q;
   logic [31:0]       addr_q;
   logic [31:0]       instr_q;
   logic              err_q;

   logic              abort;
   logic              go_ok;
   logic              req_valid;
   logic [31:0]       req_addr;
   logic              req_is_mem;
   logic              req_ready;
   logic              in_flight;
   logic              phase_end;

   assign abort     = cmd_abort && (state_q != IDLE);
   assign go_ok     = (prog_len != '0) && (prog_len <= PL_W'(IMEM_DEPTH));
   // The last word of a phase has been handed over and nothing is left to issue.
   assign phase_end = dump_valid && dump_ready && !in_flight && !req_valid;

   assign core_address     = addr_q;
   assign core_instruction = instr_q;
   assign err              = err_q;
   assign dbg_state        = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      host_ready = 1'b0;
      core_start = 1'b0;
      busy       = (state_q != IDLE);
      done       = 1'b0;
      req_valid  = 1'b0;
      req_addr   = '0;
      req_is_mem = 1'b0;
      case (state_q)
         IDLE: if (cmd_go && go_ok) state_d = LOAD;
         LOAD: begin
            host_ready = 1'b1;
            if (host_valid && (k_q == prog_len_q - PL_W'(1))) state_d = RUN;
         end
         RUN: begin
            // First RUN cycle keeps start low so the core captures the last word.
            core_start = (run_cnt_q != '0);
            if (run_cnt_q == run_q) state_d = RD_REG;
         end
         RD_REG: begin
            req_valid = (iss_q < IDX_W'(NUM_REGS));
            req_addr  = 32'(iss_q[4:0]);
            if (dump_valid && dump_ready && !in_flight && !req_valid)
               state_d = (MEM_WORDS == 0) ? DONE : RD_MEM;
         end
         RD_MEM: begin
            req_valid  = (iss_q < IDX_W'(MEM_WORDS));
            req_is_mem = 1'b1;
            req_addr   = mem_base_q + (32'(iss_q) << 2);
            if (dump_valid && dump_ready && !in_flight && !req_valid) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prog_len_q <= '0;
         run_q      <= '0;
         mem_base_q <= '0;
         k_q        <= '0;
         run_cnt_q  <= '0;
         iss_q      <= '0;
         addr_q     <= '0;
         instr_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (abort) begin
            k_q       <= '0;
            run_cnt_q <= '0;
            iss_q     <= '0;
            addr_q    <= '0;
            instr_q   <= '0;
         end else begin
            case (state_q)
               IDLE: if (cmd_go) begin
                  if (go_ok) begin
                     prog_len_q <= prog_len;
                     run_q      <= run_cycles;
                     mem_base_q <= mem_base;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               LOAD: if (host_valid) begin
                  addr_q  <= 32'(k_q) * WORD_BYTES;
                  instr_q <= host_instr;
                  k_q     <= (k_q == prog_len_q - PL_W'(1)) ? '0 : k_q + PL_W'(1);
               end
               RUN: begin
                  addr_q    <= '0;
                  instr_q   <= '0;
                  run_cnt_q <= (run_cnt_q == run_q) ? '0 : run_cnt_q + RUN_W'(1);
               end
               RD_REG, RD_MEM: begin
                  if (phase_end)                   iss_q <= '0;
                  else if (req_valid && req_ready) iss_q <= iss_q + IDX_W'(1);
               end
               default: ;
            endcase
         end
      end
   end

   readback_slot #(.READ_LAT(READ_LAT)) u_slot (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (abort),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_is_mem    (req_is_mem),
      .req_index     (iss_q[4:0]),
      .req_ready     (req_ready),
      .check_address (core_check_address),
      .data_or_reg   (core_data_or_reg),
      .core_value    (core_value),
      .out_valid     (dump_valid),
      .out_data      (dump_data),
      .out_is_mem    (dump_is_mem),
      .out_index     (dump_index),
      .out_ready     (dump_ready),
      .in_flight     (in_flight)
   );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed + randomized sessions against a behavioural core model and an
// expected readback queue.
module tb_pipeline_sequencer;
   import seq_pkg::*;

   localparam int IMEM_DEPTH = 256;
   localparam int RUN_W      = 16;
   localparam int MEM_WORDS  = 16;
   localparam int READ_LAT   = 1;
   localparam int PL_W       = $clog2(IMEM_DEPTH) + 1;

   logic              clk, rst_n;
   logic              cmd_go, cmd_abort;
   logic [PL_W-1:0]   prog_len;
   logic [RUN_W-1:0]  run_cycles;
   logic [31:0]       mem_base;
   logic              host_valid, host_ready;
   logic [31:0]       host_instr;
   logic              core_start, core_data_or_reg;
   logic [31:0]       core_address, core_instruction, core_check_address, core_value;
   logic              dump_valid, dump_is_mem, dump_ready;
   logic [31:0]       dump_data;
   logic [4:0]        dump_index;
   logic              busy, done, err;
   state_t            dbg_state;

   int checks = 0;
   int errors = 0;
   logic [37:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   pipeline_sequencer #(
      .IMEM_DEPTH(IMEM_DEPTH), .RUN_W(RUN_W), .MEM_WORDS(MEM_WORDS), .READ_LAT(READ_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_go(cmd_go), .cmd_abort(cmd_abort),
      .prog_len(prog_len), .run_cycles(run_cycles), .mem_base(mem_base),
      .host_valid(host_valid), .host_instr(host_instr), .host_ready(host_ready),
      .core_start(core_start), .core_data_or_reg(core_data_or_reg),
      .core_address(core_address), .core_instruction(core_instruction),
      .core_check_address(core_check_address), .core_value(core_value),
      .dump_valid(dump_valid), .dump_data(dump_data), .dump_is_mem(dump_is_mem),
      .dump_index(dump_index), .dump_ready(dump_ready),
      .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
   );

   // ---------------- core model: debug port with one-cycle read ----------------
   logic [31:0] regs [32];
   logic [31:0] mem_key;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ mem_key;
   endfunction

   always @(posedge clk)
      core_value <= core_data_or_reg ? mem_word(core_check_address) : regs[core_check_address[4:0]];

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ctrl"}, {host_ready, core_start, core_data_or_reg, dump_valid, dump_is_mem,
                             busy, done, err, dump_index}, 64'd0);
      check({tag, "_core"}, {core_address, core_instruction}, 64'd0);
      check({tag, "_dump"}, {core_check_address, dump_data}, 64'd0);
   endtask

   // ---------------- drivers ----------------
   task automatic drive_idle();
      cmd_go = 0; cmd_abort = 0; prog_len = '0; run_cycles = '0; mem_base = '0;
      host_valid = 0; host_instr = '0; dump_ready = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive_idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Returns at the negedge after the go edge.
   task automatic pulse_go(input int plen, input int rc, input logic [31:0] base);
      @(negedge clk);
      cmd_go = 1; prog_len = PL_W'(plen); run_cycles = RUN_W'(rc); mem_base = base;
      @(negedge clk);
      cmd_go = 0;
   endtask

   task automatic session(input int plen, input int rc, input logic [31:0] base,
                          input bit fixed, input bit rand_flow, input int stall_idx,
                          input int abort_at, input int rst_load_at, input int rst_dump_at);
      logic [31:0] prog[$];
      logic [37:0] e;
      int k, cyc, starts, got, t0, t31, dones;
      bit hs, stalled;

      prog.delete();
      exp_q.delete();
      if (fixed) prog = '{32'h0050_0093, 32'h0030_0113, 32'h0020_81B3};
      else for (int i = 0; i < plen; i++) prog.push_back($urandom);
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      regs[0] = 32'd0;
      if (fixed) begin regs[1] = 32'd5; regs[2] = 32'd3; regs[3] = 32'd8; end
      mem_key = $urandom;

      pulse_go(plen, rc, base);
      check("go_busy", {busy, err}, 64'b10);

      // program load
      k = 0; cyc = 0;
      while (k < plen && cyc < 4 * plen + 100) begin
         host_valid = rand_flow ? 1'($urandom_range(0, 1)) : 1'b1;
         host_instr = prog[k];
         if (rand_flow) begin cmd_go = 1'($urandom_range(0, 1)); prog_len = '0; end
         hs = host_valid && host_ready;
         check("load_start_low", core_start, 0);
         if (hs && rst_load_at == k) begin
            rst_n = 1'b0; drive_idle();
            #1 check_quiet("rst_mid_load");
            return;
         end
         @(posedge clk); #1;
         check("busy_go_no_err", err, 0);
         if (hs) begin
            check("load_addr", core_address, 32'(k) * 4);
            check("load_instr", core_instruction, prog[k]);
            k++;
         end
         @(negedge clk); cyc++;
      end
      host_valid = 0; cmd_go = 0;
      check("load_complete", k, plen);
      check("ready_drop", host_ready, 0);

      // run budget
      starts = 0; cyc = 0;
      while (!dump_valid && cyc < rc + 60) begin
         if (core_start) starts++;
         if (abort_at > 0 && starts == abort_at) begin
            cmd_abort = 1;
            @(posedge clk); #1;
            cmd_abort = 0;
            check("abort_quiet", {core_start, busy, host_ready, dump_valid}, 0);
            dones = 0;
            for (int i = 0; i < 6; i++) begin @(negedge clk); if (done) dones++; end
            check("abort_no_done", dones, 0);
            return;
         end
         @(negedge clk); cyc++;
      end
      check("run_len", starts, rc);
      check("run_reached_dump", dump_valid, 1);

      // readback
      for (int i = 0; i < 32; i++)
         exp_q.push_back({1'b0, 5'(i), (i == 0) ? 32'd0 : regs[i]});
      for (int j = 0; j < MEM_WORDS; j++)
         exp_q.push_back({1'b1, 5'(j), mem_word(base + 32'(j) * 4)});
      got = 0; cyc = 0; t0 = 0; t31 = 0; stalled = 0;
      while (exp_q.size() > 0 && cyc < 3000) begin
         dump_ready = rand_flow ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (dump_valid && got == rst_dump_at) begin
            rst_n = 1'b0; drive_idle();
            #1 check_quiet("rst_mid_dump");
            exp_q.delete();
            return;
         end
         if (dump_valid && got == stall_idx && !stalled) begin
            stalled = 1;
            dump_ready = 0;
            for (int s = 0; s < 10; s++) begin
               check("stall_hold", {dump_valid, dump_is_mem, dump_index, dump_data}, {1'b1, exp_q[0]});
               @(negedge clk); cyc++;
            end
            dump_ready = 1;
         end
         if (dump_valid && dump_ready) begin
            e = exp_q.pop_front();
            check("dump_word", {dump_is_mem, dump_index, dump_data}, e);
            got++;
            if (got == 1)  t0 = cyc;
            if (got == 32) t31 = cyc;
         end
         @(negedge clk); cyc++;
      end
      check("dump_count", got, 32 + MEM_WORDS);
      if (!rand_flow && stall_idx < 0)
         check("reg_throughput", t31 - t0, 31 * (READ_LAT + 1));
      dump_ready = 0;
      dones = 0;
      for (int i = 0; i < 6; i++) begin if (done) dones++; @(negedge clk); end
      check("done_once", dones, 1);
      check("idle_after", {busy, dump_valid, core_start}, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      do_reset();
      check_quiet("reset");

      // rejected commands
      pulse_go(0, 5, 32'h0);
      check("err_len0", {err, busy}, 64'b10);
      @(negedge clk);
      check("err_one_cycle", err, 0);
      pulse_go(IMEM_DEPTH + 1, 5, 32'h0);
      check("err_len_over", {err, busy}, 64'b10);
      @(negedge clk);
      check("err_over_clear", {err, busy}, 0);

      // program load, run, full readback
      session(3, 20, 32'h100, 1, 0, -1, -1, -1, -1);
      // readback stall on word 7
      session(3, 20, 32'h100, 1, 0, 7, -1, -1, -1);
      // abort in RUN, then a normal session
      session(4, 20, 32'h200, 0, 0, -1, 5, -1, -1);
      session(4, 20, 32'h200, 0, 0, -1, -1, -1, -1);
      // reset mid-LOAD and mid-RD_REG, each followed by a full session
      session(3, 20, 32'h100, 1, 0, -1, -1, 1, -1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1; @(negedge clk);
      session(3, 20, 32'h100, 1, 0, -1, -1, -1, -1);
      session(3, 20, 32'h100, 1, 0, -1, -1, -1, 10);
      repeat (2) @(negedge clk);
      rst_n = 1'b1; @(negedge clk);
      session(3, 20, 32'h100, 1, 0, -1, -1, -1, -1);
      // boundaries: zero run budget, full-depth program, wrapping memory window
      session(1, 0, 32'hFFFF_FFF8, 0, 0, -1, -1, -1, -1);
      session(IMEM_DEPTH, 3, 32'h40, 0, 0, -1, -1, -1, -1);
      // randomized flow control and parameters
      for (int n = 0; n < 4; n++)
         session($urandom_range(1, 20), $urandom_range(0, 40), $urandom, 0, 1, -1, -1, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Session controller in front of the RISC-V pipeline top level. Each session runs in order:
- streams a program from a host into the core's instruction memory;
- asserts the core's start for a programmed cycle budget;
- sweeps the core's debug readback port over all 32 registers, then a window of data memory;
- returns the readback words to the host on a valid/ready stream.

It alone owns the core's start, DataOrReg, address, instruction and check_address inputs.

Parameters:
IMEM_DEPTH, 256, instruction-memory depth in words; program length limit
RUN_W, 16, width of run-cycle budget counter
MEM_WORDS, 16, data-memory words dumped after registers
READ_LAT, 1, cycles from driving check_address/DataOrReg to valid core_value (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
cmd_go  in  1  start session (sampled in IDLE only)
cmd_abort  in  1  abort current session
prog_len  in  $clog2(IMEM_DEPTH)+1  words to load, captured on cmd_go
run_cycles  in  RUN_W  core run budget, captured on cmd_go
mem_base  in  32  byte address of first dumped data word, captured on cmd_go
host_valid  in  1  program word valid
host_instr  in  32  program word
host_ready  out  1  sequencer accepts program word
core_start  out  1  to core start
core_data_or_reg  out  1  to core DataOrReg (0=register, 1=data mem)
core_address  out  32  to core address (imem byte address)
core_instruction  out  32  to core instruction
core_check_address  out  32  to core check_address
core_value  in  32  from core value
dump_valid  out  1  readback word valid
dump_data  out  32  readback word
dump_is_mem  out  1  0=register word, 1=memory word
dump_index  out  5  register number or memory word index
dump_ready  in  1  host accepts readback word
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on session completion
err  out  1  one-cycle pulse on rejected cmd_go

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low (clk, rst_n). rst_n low at any time, mid-session included:
  - state -> IDLE;
  - all outputs 0, all counters 0.
- FSM states: IDLE, LOAD, RUN, RD_REG, RD_MEM, DONE.
- IDLE:
  - cmd_go with 1<=prog_len<=IMEM_DEPTH: capture prog_len/run_cycles/mem_base, go to LOAD.
  - cmd_go with prog_len=0 or prog_len>IMEM_DEPTH: err pulses next cycle, stay IDLE.
  - cmd_go while not IDLE: ignored, no err.
- LOAD:
  - host_ready=1; core_start=0.
  - Each host_valid&&host_ready handshake registers core_address=4*k and core_instruction=host_instr. The core captures while start is low. k increments.
  - After the prog_len-th handshake, go to RUN.
  - host_ready drops in the same cycle the last word registers; no extra word is accepted.
- RUN:
  - core_start=1 for exactly run_cycles cycles. run_cycles=0 means zero cycles: pass straight through to RD_REG with start never asserted.
  - Then core_start=0 and go to RD_REG.
- RD_REG, for i=0..31 (x0 included):
  - drive core_data_or_reg=0, core_check_address={27'b0,i};
  - wait READ_LAT cycles, register core_value into dump_data with dump_is_mem=0, dump_index=i, dump_valid=1;
  - hold dump_data/dump_is_mem/dump_index stable until dump_ready, then advance.
  - After i=31 is accepted: go to RD_MEM, or to DONE if MEM_WORDS=0.
- RD_MEM: same protocol for j=0..MEM_WORDS-1, with core_data_or_reg=1, core_check_address=mem_base+4*j (32-bit wrap), dump_is_mem=1, dump_index=j[4:0].
- DONE: done=1 for one cycle, then IDLE.
- Readback throughput: back-to-back dump_ready gives 1 word per READ_LAT+1 cycles.
- cmd_abort in any non-IDLE state:
  - next cycle IDLE, core_start=0, dump_valid=0, host_ready=0;
  - no done pulse;
  - abort wins over simultaneous last handshake or terminal count.
- Outputs outside their active states hold 0: core_address, core_instruction, core_check_address, core_data_or_reg, dump_*.

Decomposition:
- Shared package seq_pkg: state enum (IDLE..DONE), NUM_REGS=32, WORD_BYTES=4.
- Single sub-module readback_slot: issues check_address/DataOrReg, counts READ_LAT, and holds one output word under valid/ready. Used by both RD_REG and RD_MEM.

Test Plan:
1. prog_len=3, words 0x00500093/0x00300113/0x002081B3, host_valid always high -> core_address 0,4,8 on successive cycles; host_ready low afterward; RUN start high exactly run_cycles=20 cycles.
2. Continuation of 1 with a core model returning x1=5, x2=3, x3=8 and dump_ready always high -> 32 register words in order, indices 0..31, x0=0; then MEM_WORDS words at mem_base=0x100, 0x104, ...; done pulses once.
3. dump_ready held low 10 cycles on word 7 -> dump_data/dump_index stable throughout; no word skipped or duplicated.
4. cmd_go with prog_len=0, then prog_len=IMEM_DEPTH+1 -> err pulses each time; busy stays 0.
5. cmd_abort during RUN at cycle 5 of 20 -> core_start low next cycle, IDLE, no done; a new cmd_go then runs normally.
6. rst_n low mid-LOAD and mid-RD_REG -> all outputs 0 asynchronously; after release, a full session matches scenario 2.
